demux_1_2_buf: RTL and testbench

- Registered 1-to-2 demultiplexer; the distribution counterpart of the 2:1 datapath mux.
- Steers each accepted 24-bit word from a single valid/ready source to one of two sinks, selected per transfer.
- Each sink has its own small FIFO, so one stalled sink never corrupts or reorders traffic to the other.
- Used on the CPU24 datapath wherever one producer feeds two consumers, e.g. result routing to two units.

---
 rtl/demux_1_2_buf_if.sv | 30 +++
 rtl/demux_1_2_buf.sv | 79 +++++++
 tb/tb_demux_1_2_buf.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/demux_1_2_buf_if.sv
// Handshake bundle for demux_1_2_buf: one valid/ready source, two valid/ready sinks
// and the per-sink accepted-word counters.
interface demux_1_2_buf_if #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CNTW  = 8
);
  logic             enb;
  logic [0:WIDTH-1] a;
  logic             sel;
  logic             a_valid;
  logic             a_ready;
  logic [0:WIDTH-1] y0;
  logic             y0_valid;
  logic             y0_ready;
  logic [0:WIDTH-1] y1;
  logic             y1_valid;
  logic             y1_ready;
  logic [CNTW-1:0]  cnt0;
  logic [CNTW-1:0]  cnt1;

  modport master (
    output enb, a, sel, a_valid, y0_ready, y1_ready,
    input  a_ready, y0, y0_valid, y1, y1_valid, cnt0, cnt1
  );

  modport slave (
    input  enb, a, sel, a_valid, y0_ready, y1_ready,
    output a_ready, y0, y0_valid, y1, y1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux_1_2_buf.sv
// Registered 1-to-2 demultiplexer: each accepted word is queued in the FIFO of the
// sink chosen by sel; the two FIFOs drain independently.
module demux_1_2_buf #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNTW  = 8
) (
  input logic            clk,
  input logic            rst,
  demux_1_2_buf_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [0:WIDTH-1] r_mem [2][DEPTH];
  logic [AW:0]      r_wp  [2];
  logic [AW:0]      r_rp  [2];
  logic [CNTW-1:0]  r_cnt [2];

  logic [1:0] w_full;
  logic [1:0] w_empty;
  logic [1:0] w_push;
  logic [1:0] w_pop;
  logic [1:0] w_dst;
  logic       w_ready;

  // Pointers carry an extra wrap bit so DEPTH+1 occupancy states are distinguishable.
  always_comb begin
    w_full  = '0;
    w_empty = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      w_empty[i] = (r_wp[i] == r_rp[i]);
      w_full[i]  = (r_wp[i][AW] != r_rp[i][AW]) &&
                   (r_wp[i][AW-1:0] == r_rp[i][AW-1:0]);
    end
    w_dst   = {bus.sel, ~bus.sel};
    w_ready = bus.enb & ~rst & ~w_full[bus.sel];
    w_push  = {2{bus.a_valid & w_ready}} & w_dst;
    w_pop   = {bus.y1_ready, bus.y0_ready} & ~w_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (w_push[i]) begin
          r_wp[i]  <= r_wp[i] + {{AW{1'b0}}, 1'b1};
          r_cnt[i] <= r_cnt[i] + {{(CNTW-1){1'b0}}, 1'b1};
        end
        if (w_pop[i]) begin
          r_rp[i] <= r_rp[i] + {{AW{1'b0}}, 1'b1};
        end
      end
    end
  end

  // Storage needs no reset: heads are masked to zero while a FIFO is empty.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wp[i][AW-1:0]] <= bus.a;
      end
    end
  end

  always_comb begin
    bus.a_ready  = w_ready;
    bus.y0_valid = ~w_empty[0];
    bus.y1_valid = ~w_empty[1];
    bus.y0       = w_empty[0] ? '0 : r_mem[0][r_rp[0][AW-1:0]];
    bus.y1       = w_empty[1] ? '0 : r_mem[1][r_rp[1][AW-1:0]];
    bus.cnt0     = r_cnt[0];
    bus.cnt1     = r_cnt[1];
  end
endmodule

// File: tb/tb_demux_1_2_buf.sv
// Scoreboard bench for demux_1_2_buf: accepted words are queued per destination,
// and a monitor compares each sink's head against its queue every cycle.
module tb_demux_1_2_buf;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_1_2_buf_if #(.WIDTH(24), .CNTW(8)) bus ();

  demux_1_2_buf #(.WIDTH(24), .DEPTH(DEPTH), .CNTW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [0:23] q0[$];
  logic [0:23] q1[$];
  logic [7:0]  m_cnt0 = '0;
  logic [7:0]  m_cnt1 = '0;
  bit          chk_en = 1'b0;
  bit          m_acc  = 1'b0;
  bit          pop0   = 1'b0;
  bit          pop1   = 1'b0;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", n, $time, act, exp);
    end
  endfunction

  // Monitor: sink heads, valids and counters against the model, popping on handshake.
  always @(negedge clk) begin
    logic [0:23] e0;
    logic [0:23] e1;
    pop0 = 1'b0;
    pop1 = 1'b0;
    if (chk_en) begin
      e0 = (q0.size() > 0) ? q0[0] : '0;
      e1 = (q1.size() > 0) ? q1[0] : '0;
      chk("y0_valid", 32'(bus.y0_valid), 32'(q0.size() > 0));
      chk("y1_valid", 32'(bus.y1_valid), 32'(q1.size() > 0));
      chk("y0", {8'h00, bus.y0}, {8'h00, e0});
      chk("y1", {8'h00, bus.y1}, {8'h00, e1});
      chk("cnt0", {24'h0, bus.cnt0}, {24'h0, m_cnt0});
      chk("cnt1", {24'h0, bus.cnt1}, {24'h0, m_cnt1});
      if (!rst && bus.y0_ready && q0.size() > 0) begin
        void'(q0.pop_front());
        pop0 = 1'b1;
      end
      if (!rst && bus.y1_ready && q1.size() > 0) begin
        void'(q1.pop_front());
        pop1 = 1'b1;
      end
    end
  end

  // Issue side: expected a_ready from pre-edge occupancy, record accepted words.
  always @(negedge clk) begin
    bit er;
    int occ;
    #1;
    occ = bus.sel ? (q1.size() + int'(pop1)) : (q0.size() + int'(pop0));
    er  = bus.enb && !rst && (occ < DEPTH);
    chk("a_ready", 32'(bus.a_ready), 32'(er));
    m_acc = bus.a_valid && er;
    if (rst) begin
      q0.delete();
      q1.delete();
      m_cnt0 = '0;
      m_cnt1 = '0;
    end else if (m_acc) begin
      if (bus.sel) begin
        q1.push_back(bus.a);
        m_cnt1 = m_cnt1 + 8'd1;
      end else begin
        q0.push_back(bus.a);
        m_cnt0 = m_cnt0 + 8'd1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_valid = 1'b0;
    cyc();
  endtask

  task automatic send(input logic [0:23] d, input logic s);
    bus.a       = d;
    bus.sel     = s;
    bus.a_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      cyc();
      if (m_acc) return;
    end
    tests++;
    fails++;
    $display("FAIL send_timeout: word %h sel %0d not accepted, required within 64 cycles", d, s);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.enb      = 1'b1;
    bus.a        = '0;
    bus.sel      = 1'b0;
    bus.a_valid  = 1'b1;
    bus.y0_ready = 1'b1;
    bus.y1_ready = 1'b1;
    cyc();
    cyc();
    rst         = 1'b0;
    bus.a_valid = 1'b0;
    chk_en      = 1'b1;
    cyc();

    // Basic steering
    send(24'h010101, 1'b0);
    send(24'h020202, 1'b1);
    idle();
    cyc();

    // Backpressure: FIFO0 fills, FIFO1 still accepts, then FIFO0 drains
    bus.y0_ready = 1'b0;
    send(24'h0A0A0A, 1'b0);
    send(24'h0B0B0B, 1'b0);
    send(24'h0D0D0D, 1'b1);
    fork
      send(24'h0C0C0C, 1'b0);
      begin
        repeat (3) cyc();
        bus.y0_ready = 1'b1;
      end
    join
    idle();
    repeat (3) cyc();

    // Simultaneous push/pop on FIFO1 holding one word
    bus.y1_ready = 1'b0;
    send(24'h030303, 1'b1);
    bus.y1_ready = 1'b1;
    send(24'h111111, 1'b1);
    idle();
    cyc();

    // enb=0 blocks acceptance while sinks drain
    bus.y0_ready = 1'b0;
    send(24'h040404, 1'b0);
    send(24'h050505, 1'b0);
    bus.enb      = 1'b0;
    bus.a        = 24'hFFFFFF;
    bus.sel      = 1'b0;
    bus.a_valid  = 1'b1;
    bus.y0_ready = 1'b1;
    repeat (4) cyc();
    bus.enb = 1'b1;
    send(24'hFFFFFF, 1'b0);
    idle();
    cyc();

    // Counter wrap
    for (int k = 0; k < 256; k++) send(24'($urandom), 1'b0);
    idle();
    cyc();

    // Reset with both FIFOs full
    bus.y0_ready = 1'b0;
    bus.y1_ready = 1'b0;
    send(24'h121212, 1'b0);
    send(24'h131313, 1'b0);
    send(24'h141414, 1'b1);
    send(24'h151515, 1'b1);
    bus.a_valid = 1'b0;
    rst         = 1'b1;
    cyc();
    rst          = 1'b0;
    bus.y0_ready = 1'b1;
    bus.y1_ready = 1'b1;
    repeat (3) cyc();

    // Randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      if (!bus.a_valid || m_acc) begin
        bus.a_valid = ($urandom_range(3) != 0);
        bus.a       = 24'($urandom);
        bus.sel     = 1'($urandom_range(1));
      end
      bus.enb      = ($urandom_range(9) != 0);
      bus.y0_ready = 1'($urandom_range(1));
      bus.y1_ready = ($urandom_range(3) != 0);
      rst          = ($urandom_range(299) == 0);
      cyc();
    end
    rst          = 1'b0;
    bus.enb      = 1'b1;
    bus.a_valid  = 1'b0;
    bus.y0_ready = 1'b1;
    bus.y1_ready = 1'b1;
    repeat (8) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
